// File: rtl/z80_rel_jump_seq.sv
// Z80 relative-jump sequencer: JR e, JR cc,e and (optionally) DJNZ e, one T-state per clock.
// Define Z80_REL_JUMP_SEQ_DJNZ_EN to execute DJNZ (0x10); otherwise it is reported as illegal.
module z80_rel_jump_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] ip_in,
    input  logic [7:0]  f_in,
    input  logic [7:0]  b_in,
    output logic        mem_rd_req,
    output logic [15:0] mem_rd_addr,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        busy,
    output logic [1:0]  mcyc,
    output logic        done,
    output logic        taken,
    output logic        illegal,
    output logic [15:0] ip_out,
    output logic [7:0]  b_out,
    output logic        b_we,
    output logic [3:0]  tstates
);

    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] MCYC_NONE = 2'd0;
    localparam logic [1:0] MCYC_READ = 2'd1;
    localparam logic [1:0] MCYC_INT  = 2'd2;
    localparam logic [1:0] MCYC_DEC  = 2'd3;

    localparam logic [CNT_W-1:0] READ_MIN   = CNT_W'(3);
    localparam logic [CNT_W-1:0] INT_CYCLES = CNT_W'(5);

    localparam logic [7:0] OP_JR    = 8'h18;
    localparam logic [7:0] OP_JR_NZ = 8'h20;
    localparam logic [7:0] OP_JR_Z  = 8'h28;
    localparam logic [7:0] OP_JR_NC = 8'h30;
    localparam logic [7:0] OP_JR_C  = 8'h38;
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
    localparam logic [7:0] OP_DJNZ  = 8'h10;
`endif

`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
    typedef enum logic [2:0] {IDLE, DEC, READ, INTERNAL, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, INTERNAL, FIN} state_t;
`endif

    state_t             state;
    logic [7:0]         op_q;
    logic [15:0]        ip_q;
    logic               z_q;
    logic               c_q;
    logic [7:0]         disp_q;
    logic               got_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         tcnt_q;
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
    logic [7:0]         b_q;
`endif

    logic               legal_c;
    logic               ack_c;
    logic [7:0]         disp_c;
    logic               cond_c;
    logic [15:0]        target_c;
    logic [15:0]        fall_c;
    logic [3:0]         tnext_c;
    logic               read_exit_c;

    // Only Z and C participate in condition evaluation.
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
    logic unused_bits;
    assign unused_bits = ^{f_in[7], f_in[5:1]};
`else
    logic unused_bits;
    assign unused_bits = ^{f_in[7], f_in[5:1], b_in};
`endif

    // Opcode decode, branch condition and next-IP arithmetic.
    always_comb begin
        legal_c     = 1'b0;
        ack_c       = mem_rd_req & mem_rd_ack;
        disp_c      = ack_c ? mem_rd_data : disp_q;
        cond_c      = 1'b0;
        fall_c      = 16'(ip_q + 16'd2);
        target_c    = 16'(fall_c + {{8{disp_c[7]}}, disp_c});
        tnext_c     = (tcnt_q == 4'hF) ? tcnt_q : 4'(tcnt_q + 4'd1);
        read_exit_c = (got_q | ack_c) & (cnt_q >= READ_MIN);

        case (opcode)
            OP_JR, OP_JR_NZ, OP_JR_Z, OP_JR_NC, OP_JR_C: legal_c = 1'b1;
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
            OP_DJNZ:                                     legal_c = 1'b1;
`endif
            default:                                     legal_c = 1'b0;
        endcase

        if (op_q == OP_JR) begin
            cond_c = 1'b1;
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
        end else if (op_q == OP_DJNZ) begin
            cond_c = (b_q != 8'h01);
`endif
        end else begin
            case (op_q[4:3])
                2'b00:   cond_c = ~z_q;
                2'b01:   cond_c = z_q;
                2'b10:   cond_c = ~c_q;
                default: cond_c = c_q;
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 8'h00;
            ip_q        <= 16'h0000;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            disp_q      <= 8'h00;
            got_q       <= 1'b0;
            cnt_q       <= '0;
            tcnt_q      <= 4'h0;
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
            b_q         <= 8'h00;
`endif
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= 16'h0000;
            busy        <= 1'b0;
            mcyc        <= MCYC_NONE;
            done        <= 1'b0;
            taken       <= 1'b0;
            illegal     <= 1'b0;
            ip_out      <= 16'h0000;
            b_out       <= 8'h00;
            b_we        <= 1'b0;
            tstates     <= 4'h0;
        end else begin
            done    <= 1'b0;
            taken   <= 1'b0;
            illegal <= 1'b0;
            b_we    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && legal_c) begin
                        op_q        <= opcode;
                        ip_q        <= ip_in;
                        z_q         <= f_in[6];
                        c_q         <= f_in[0];
                        got_q       <= 1'b0;
                        tcnt_q      <= 4'h0;
                        busy        <= 1'b1;
                        mem_rd_addr <= 16'(ip_in + 16'd1);
`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
                        b_q         <= b_in;
                        if (opcode == OP_DJNZ) begin
                            state <= DEC;
                            mcyc  <= MCYC_DEC;
                            b_we  <= 1'b1;
                            b_out <= 8'(b_in - 8'd1);
                        end else begin
                            state      <= READ;
                            mcyc       <= MCYC_READ;
                            mem_rd_req <= 1'b1;
                            cnt_q      <= CNT_W'(1);
                        end
`else
                        state      <= READ;
                        mcyc       <= MCYC_READ;
                        mem_rd_req <= 1'b1;
                        cnt_q      <= CNT_W'(1);
`endif
                    end else if (start) begin
                        // Unsupported opcode: report immediately, no operand read.
                        state   <= FIN;
                        busy    <= 1'b1;
                        mcyc    <= MCYC_NONE;
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        ip_out  <= ip_in;
                        tstates <= 4'h0;
                    end
                end

`ifdef Z80_REL_JUMP_SEQ_DJNZ_EN
                DEC: begin
                    state      <= READ;
                    mcyc       <= MCYC_READ;
                    mem_rd_req <= 1'b1;
                    cnt_q      <= CNT_W'(1);
                    tcnt_q     <= tnext_c;
                end
`endif

                READ: begin
                    tcnt_q <= tnext_c;
                    if (ack_c) begin
                        mem_rd_req <= 1'b0;
                        disp_q     <= mem_rd_data;
                        got_q      <= 1'b1;
                    end
                    // Minimum three READ T-states; wait states stretch it to the ack cycle.
                    if (read_exit_c) begin
                        if (cond_c) begin
                            state <= INTERNAL;
                            mcyc  <= MCYC_INT;
                            cnt_q <= CNT_W'(1);
                        end else begin
                            state   <= FIN;
                            mcyc    <= MCYC_NONE;
                            done    <= 1'b1;
                            ip_out  <= fall_c;
                            tstates <= tnext_c;
                        end
                    end else if (cnt_q != READ_MIN) begin
                        cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
                    end
                end

                INTERNAL: begin
                    tcnt_q <= tnext_c;
                    if (cnt_q == INT_CYCLES) begin
                        state   <= FIN;
                        mcyc    <= MCYC_NONE;
                        done    <= 1'b1;
                        taken   <= 1'b1;
                        ip_out  <= target_c;
                        tstates <= tnext_c;
                    end else begin
                        cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    mcyc  <= MCYC_NONE;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mcyc       <= MCYC_NONE;
                    mem_rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
